// File: rtl/sng_pkg.sv
// rtl/sng_pkg.sv - shared state type, default LFSR constants and per-channel seed helper
package sng_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [7:0] DEF_TAPS8 = 8'hB8;
   localparam logic [7:0] DEF_SEED8 = 8'hFF;

   // Rotate the (width-bit) seed left by 3*i; a zero seed is replaced by all-ones
   // so that no channel can ever start in the LFSR lock-up state.
   function automatic logic [31:0] rotl_seed(input logic [31:0] seed,
                                             input int unsigned i,
                                             input int unsigned width);
      logic [31:0] mask;
      logic [31:0] s;
      logic [31:0] r;
      int unsigned sh;
      logic [4:0]  idx;
      mask = (32'd1 << width) - 32'd1;
      s    = seed & mask;
      if (s == 32'd0) s = mask;
      sh   = (3 * i) % width;
      r    = 32'd0;
      for (int unsigned b = 0; b < 32; b++) begin
         if (b < width) begin
            idx    = 5'((b + sh) % width);
            r[idx] = s[b[4:0]];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sng_lfsr_multi_if.sv
// rtl/sng_lfsr_multi_if.sv - control and stochastic-stream bundle of the multi-channel SNG
interface sng_lfsr_multi_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 2,
   parameter int LW    = 9
);
   logic                 start;
   logic [LW-1:0]        len;
   logic                 share;
   logic [NCH*WIDTH-1:0] thr;
   logic                 busy;
   logic                 out_valid;
   logic [NCH-1:0]       out_bits;
   logic                 done;

   modport master (
      output start, len, share, thr,
      input  busy, out_valid, out_bits, done
   );

   modport slave (
      input  start, len, share, thr,
      output busy, out_valid, out_bits, done
   );
endinterface

// File: rtl/sng_lfsr.sv
// rtl/sng_lfsr.sv - Fibonacci LFSR with seed load and step enable
module sng_lfsr
   import sng_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   // Reset and load both restore the seed; otherwise shift in the tap parity when enabled.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         q <= seed;
      end else if (en) begin
         q <= {q[WIDTH-2:0], ^(q & TAPS)};
      end
   end

endmodule

// File: rtl/sng_lfsr_multi.sv
// rtl/sng_lfsr_multi.sv - multi-channel stochastic number generator producing framed bursts
module sng_lfsr_multi
   import sng_pkg::*;
#(
   parameter int               WIDTH           = 8,
   parameter int               NCH             = 2,
   parameter int               LW              = 9,
   parameter logic [WIDTH-1:0] TAPS            = DEF_TAPS8,
   parameter logic [WIDTH-1:0] SEED            = DEF_SEED8,
   parameter bit               RESEED_ON_START = 1'b1
) (
   input logic             clk,
   input logic             rst,
   sng_lfsr_multi_if.slave bus
);

   state_t               state;
   state_t               state_d;
   logic [LW-1:0]        cnt;
   logic [LW-1:0]        cnt_d;
   logic [LW-1:0]        len_q;
   logic [NCH*WIDTH-1:0] thr_q;
   logic                 share_q;
   logic [WIDTH-1:0]     lfsr_q [NCH];
   logic [NCH-1:0]       cmp;
   logic [NCH-1:0]       bits_d;
   logic                 valid_d;
   logic                 done_d;
   logic                 accept;
   logic                 step;
   logic                 load;

   assign load = accept && RESEED_ON_START;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam logic [31:0] SEED_W = rotl_seed(32'(SEED), i, WIDTH);

      sng_lfsr #(
         .WIDTH (WIDTH),
         .TAPS  (TAPS)
      ) u_lfsr (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .seed (SEED_W[WIDTH-1:0]),
         .en   (step),
         .q    (lfsr_q[i])
      );

      // Shared mode feeds every comparator from channel 0 to get correlated streams.
      assign cmp[i] = (share_q ? lfsr_q[0] : lfsr_q[i]) < thr_q[i*WIDTH +: WIDTH];
   end

   assign bus.busy = (state == RUN);

   // Next-state and next-output decode for the IDLE/RUN burst sequencer.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      valid_d = 1'b0;
      bits_d  = '0;
      done_d  = 1'b0;
      accept  = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  done_d = 1'b1;
               end else begin
                  accept  = 1'b1;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            step    = 1'b1;
            valid_d = 1'b1;
            bits_d  = cmp;
            cnt_d   = cnt + LW'(1);
            if (cnt_d == len_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Bit counter, burst parameter latches and registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         len_q         <= '0;
         thr_q         <= '0;
         share_q       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_bits  <= '0;
         bus.done      <= 1'b0;
      end else begin
         cnt           <= cnt_d;
         bus.out_valid <= valid_d;
         bus.out_bits  <= bits_d;
         bus.done      <= done_d;
         if (accept) begin
            len_q   <= bus.len;
            thr_q   <= bus.thr;
            share_q <= bus.share;
         end
      end
   end

endmodule

// File: tb/tb_sng_lfsr_multi.sv
// tb/tb_sng_lfsr_multi.sv - self-checking bench for the multi-channel SNG
module tb_sng_lfsr_multi;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       t_start [2];
   logic [8:0] t_len   [2];
   logic       t_share [2];
   logic [15:0] t_thr  [2];

   sng_lfsr_multi_if #(.WIDTH(8), .NCH(2), .LW(9)) bus0 ();
   sng_lfsr_multi_if #(.WIDTH(8), .NCH(2), .LW(9)) bus1 ();

   assign bus0.start = t_start[0];
   assign bus0.len   = t_len[0];
   assign bus0.share = t_share[0];
   assign bus0.thr   = t_thr[0];
   assign bus1.start = t_start[1];
   assign bus1.len   = t_len[1];
   assign bus1.share = t_share[1];
   assign bus1.thr   = t_thr[1];

   sng_lfsr_multi dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   sng_lfsr_multi #(
      .SEED            (8'h01),
      .RESEED_ON_START (1'b0)
   ) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // {busy, out_valid, done, out_bits[1:0]}
   logic [4:0] obs   [2];
   logic [4:0] exp_o [2];
   assign obs[0] = {bus0.busy, bus0.out_valid, bus0.done, bus0.out_bits};
   assign obs[1] = {bus1.busy, bus1.out_valid, bus1.done, bus1.out_bits};

   // Model: each LFSR is a position on the single 255-long m-sequence cycle.
   logic [7:0] orbit [255];
   int         spos  [2][2];
   bit         reseed_cfg [2];
   logic [7:0] seed_cfg   [2];
   bit         m_run  [2];
   int         m_rem  [2];
   int         m_pos  [2][2];
   logic [7:0] m_thr  [2][2];
   bit         m_share[2];
   logic [1:0] mb;
   logic       mv;
   logic       md;

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         mb = 2'b00;
         mv = 1'b0;
         md = 1'b0;
         if (rst) begin
            m_run[m] = 1'b0;
            for (int c = 0; c < 2; c++) m_pos[m][c] = spos[m][c];
         end else if (!m_run[m]) begin
            if (t_start[m] && t_len[m] == 9'd0) begin
               md = 1'b1;
            end else if (t_start[m]) begin
               m_run[m]    = 1'b1;
               m_rem[m]    = int'(t_len[m]);
               m_thr[m][0] = t_thr[m][7:0];
               m_thr[m][1] = t_thr[m][15:8];
               m_share[m]  = t_share[m];
               if (reseed_cfg[m])
                  for (int c = 0; c < 2; c++) m_pos[m][c] = spos[m][c];
            end
         end else begin
            for (int c = 0; c < 2; c++)
               mb[c] = orbit[m_pos[m][m_share[m] ? 0 : c]] < m_thr[m][c];
            mv = 1'b1;
            for (int c = 0; c < 2; c++) m_pos[m][c] = (m_pos[m][c] + 1) % 255;
            m_rem[m] = m_rem[m] - 1;
            if (m_rem[m] == 0) begin
               md       = 1'b1;
               m_run[m] = 1'b0;
            end
         end
         exp_o[m] = {m_run[m], mv, md, mb};
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs[m] !== exp_o[m]) begin
               n_err++;
               $display("FAIL cycle dut%0d t=%0t busy/valid/done/bits got %b want %b",
                        m, $time, obs[m], exp_o[m]);
            end
         end
      end
   end

   // Capture of valid bits and done pulses per instance.
   logic [1:0] cap0 [$];
   logic [1:0] cap1 [$];
   logic [1:0] saved [$];
   int dc [2];
   int da [2];

   always @(posedge clk) begin
      #1;
      if (obs[0][3]) cap0.push_back(obs[0][1:0]);
      if (obs[0][2]) begin dc[0]++; da[0] = cap0.size(); end
      if (obs[1][3]) cap1.push_back(obs[1][1:0]);
      if (obs[1][2]) begin dc[1]++; da[1] = cap1.size(); end
   end

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic clr();
      cap0.delete();
      cap1.delete();
      dc[0] = 0; dc[1] = 0;
      da[0] = -1; da[1] = -1;
   endtask

   task automatic rst_pulse();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   // Start a burst, scramble the inputs while it runs, then wait it out.
   task automatic burst(input int m, input int len, input logic [7:0] th0,
                        input logic [7:0] th1, input logic sh, input int tail);
      @(negedge clk);
      t_start[m] = 1'b1;
      t_len[m]   = 9'(len);
      t_thr[m]   = {th1, th0};
      t_share[m] = sh;
      @(negedge clk);
      t_start[m] = 1'b0;
      t_len[m]   = 9'd3;
      t_thr[m]   = ~{th1, th0};
      t_share[m] = ~sh;
      repeat (len + tail) @(negedge clk);
   endtask

   function automatic int pack_ch(input int m, input int c, input int n);
      int r;
      r = 0;
      for (int k = 0; k < n; k++) begin
         if (m == 0) r = r | (int'(cap0[k][c]) << k);
         else        r = r | (int'(cap1[k][c]) << k);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] s, input int sh);
      logic [15:0] d;
      d = {s, s} << sh;
      return d[15:8];
   endfunction

   int ones0, ones1, diffs;
   logic [7:0] v;
   logic [7:0] sd;

   initial begin
      for (int m = 0; m < 2; m++) begin
         t_start[m] = 1'b0;
         t_len[m]   = 9'd0;
         t_share[m] = 1'b0;
         t_thr[m]   = 16'h0000;
      end
      reseed_cfg[0] = 1'b1;
      reseed_cfg[1] = 1'b0;
      seed_cfg[0]   = 8'hFF;
      seed_cfg[1]   = 8'h01;
      v = 8'hFF;
      for (int k = 0; k < 255; k++) begin
         orbit[k] = v;
         v = {v[6:0], ^(v & 8'hB8)};
      end
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < 2; c++) begin
            sd = rotl8(seed_cfg[m], (3 * c) % 8);
            for (int k = 0; k < 255; k++)
               if (orbit[k] == sd) spos[m][c] = k;
         end
      clr();

      // Pin the model against hand-computed values.
      chk("orbit0", int'(orbit[0]), 'hFF);
      chk("orbit3", int'(orbit[3]), 'hF8);
      chk("orbit10", int'(orbit[10]), 'h2F);
      chk("rotl_seed_ch1", int'(rotl8(8'h01, 3)), 'h08);

      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Full period, thr0=128 / thr1=0.
      clr();
      burst(0, 255, 8'd128, 8'd0, 1'b0, 3);
      ones0 = 0; ones1 = 0;
      foreach (cap0[k]) begin ones0 += int'(cap0[k][0]); ones1 += int'(cap0[k][1]); end
      chk("t1_valid_count", cap0.size(), 255);
      chk("t1_ones_ch0", ones0, 127);
      chk("t1_ones_ch1", ones1, 0);
      chk("t1_done_count", dc[0], 1);
      chk("t1_done_pos", da[0], 255);

      // Seed values FF, FE, FC against two thresholds.
      clr();
      burst(0, 3, 8'h80, 8'h00, 1'b0, 2);
      chk("t3_bits_thr80", pack_ch(0, 0, 3), 'b000);
      clr();
      burst(0, 3, 8'hFD, 8'h00, 1'b0, 2);
      chk("t3_bits_thrFD", pack_ch(0, 0, 3), 'b100);

      // start during a burst is ignored.
      clr();
      @(negedge clk);
      t_start[0] = 1'b1; t_len[0] = 9'd20; t_thr[0] = 16'h4090;
      @(negedge clk) t_start[0] = 1'b0;
      repeat (4) @(negedge clk);
      t_start[0] = 1'b1; t_len[0] = 9'd5;
      @(negedge clk) t_start[0] = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4_len_count", cap0.size(), 20);
      chk("t4_done_count", dc[0], 1);
      chk("t4_done_pos", da[0], 20);

      // len=0 gives a bare done.
      clr();
      @(negedge clk);
      t_start[0] = 1'b1; t_len[0] = 9'd0;
      @(negedge clk) t_start[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4_len0_valids", cap0.size(), 0);
      chk("t4_len0_done", dc[0], 1);

      // Reset mid-burst, then replay from the seed.
      clr();
      @(negedge clk);
      t_start[0] = 1'b1; t_len[0] = 9'd100; t_thr[0] = 16'h80FD;
      @(negedge clk) t_start[0] = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_rst_outputs", int'(obs[0][4:2]), 0);
      @(negedge clk) rst = 1'b0;
      saved = cap0;
      chk("t5_bits_before_rst", saved.size(), 9);
      chk("t5_no_done", dc[0], 0);
      clr();
      burst(0, 10, 8'hFD, 8'h80, 1'b0, 2);
      chk("t5_replay_ch0", pack_ch(0, 0, 10), 'b1111111100);
      chk("t5_replay_ch1", pack_ch(0, 1, 10), 'b1100000000);
      diffs = 0;
      foreach (saved[k]) if (saved[k] !== cap0[k]) diffs++;
      chk("t5_replay_matches_prefix", diffs, 0);

      // Shared vs independent LFSRs on the instance with distinct channel seeds.
      rst_pulse();
      clr();
      burst(1, 50, 8'd100, 8'd100, 1'b1, 2);
      diffs = 0;
      foreach (cap1[k]) if (cap1[k][0] !== cap1[k][1]) diffs++;
      chk("t2_share_count", cap1.size(), 50);
      chk("t2_share_equal", diffs, 0);
      clr();
      burst(1, 50, 8'd100, 8'd100, 1'b0, 2);
      diffs = 0;
      foreach (cap1[k]) if (cap1[k][0] !== cap1[k][1]) diffs++;
      chk("t2_noshare_differs", int'(diffs > 0), 1);

      // No reseed: two 10-bit bursts continue one 20-bit sequence.
      rst_pulse();
      clr();
      burst(1, 20, 8'h90, 8'h30, 1'b0, 2);
      saved = cap1;
      rst_pulse();
      clr();
      burst(1, 10, 8'h90, 8'h30, 1'b0, 2);
      burst(1, 10, 8'h90, 8'h30, 1'b0, 2);
      chk("t6_total_bits", cap1.size(), 20);
      chk("t6_done_count", dc[1], 2);
      diffs = 0;
      for (int k = 0; k < 20; k++)
         if (k < cap1.size() && k < saved.size() && saved[k] !== cap1[k]) diffs++;
      chk("t6_continuation", diffs, 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
